adc_avg_bcd: RTL and testbench

Downstream consumer of the ADC0804 sample stage. It block-averages 2^AVG_LOG2 consecutive 8-bit conversions and scales the mean by 2 to centivolts (0–510 → 0.00–5.10 V). An iterative double-dabble converter turns the result into three BCD digits for the 7-segment scan driver. It replaces the per-scan divide/modulo arithmetic with one registered, handshaked result per averaging block.

---
 rtl/adc_avg_bcd.sv | 203 ++++++++++++++++++++
 tb/tb_adc_avg_bcd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_bcd.sv
// Block-averages ADC samples, scales the mean to centivolts and converts it
// to three BCD digits with a serial double-dabble, one result per block.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-low reset
//   sample_in    8-bit ADC conversion result
//   sample_valid strobe, sample_in accepted in every cycle it is high
//   avg_out      most recent block mean (truncated)
//   bcd_hund     hundreds digit of mean*2
//   bcd_tens     tens digit of mean*2
//   bcd_ones     ones digit of mean*2
//   bcd_valid    one-cycle pulse when the digits update
//   busy         conversion in progress
//   overrun      sticky, a pending block was overwritten
module adc_avg_bcd #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] avg_out,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bcd_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  state_e      state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  avg_q, avg_d;
  logic [8:0]  sh_q, sh_d;
  logic [11:0] scr_q, scr_d;
  logic [3:0]  sc_q, sc_d;
  logic        pend_q, pend_d;
  logic [8:0]  pval_q, pval_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        valid_q, valid_d;

  logic [AW-1:0] sum;
  logic          blk_last;
  logic          blk_done;
  logic [7:0]    mean;
  logic [8:0]    value;
  logic [11:0]   adj;
  logic [11:0]   scr_sh;
  logic [8:0]    sh_sh;
  logic          fin;

  assign sum      = acc_q + AW'(sample_in);
  // With a one-sample window every accepted sample closes the block.
  assign blk_last = (AVG_LOG2 == 0) || (cnt_q == CW'(NS - 1));
  assign blk_done = sample_valid && blk_last;
  assign mean     = sum[AVG_LOG2 +: 8];
  assign value    = {mean, 1'b0};

  // Double-dabble step: correct each nibble, then shift in the next bit.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 3; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {scr_sh, sh_sh} = {adj, sh_q} << 1;
  assign fin = (sc_q == 4'd8);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    if (sample_valid) begin
      if (blk_last) begin
        acc_d = '0;
        cnt_d = '0;
        avg_d = mean;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    sc_d    = sc_q;
    pend_d  = pend_q;
    pval_d  = pval_q;
    ovr_d   = ovr_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (blk_done) begin
          sh_d    = value;
          scr_d   = '0;
          sc_d    = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = sh_sh;
        scr_d = scr_sh;
        sc_d  = sc_q + 4'd1;
        if (fin) begin
          hund_d  = scr_sh[11:8];
          tens_d  = scr_sh[7:4];
          ones_d  = scr_sh[3:0];
          valid_d = 1'b1;
          // The pending block is consumed here, so a block closing on
          // this same edge takes its slot without counting as overrun.
          if (pend_q) begin
            sh_d   = pval_q;
            scr_d  = '0;
            sc_d   = '0;
            pend_d = blk_done;
            if (blk_done) begin
              pval_d = value;
            end
          end else if (blk_done) begin
            sh_d  = value;
            scr_d = '0;
            sc_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (blk_done) begin
          if (pend_q) begin
            ovr_d = 1'b1;
          end
          pend_d = 1'b1;
          pval_d = value;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      sc_q    <= '0;
      pend_q  <= 1'b0;
      pval_q  <= '0;
      ovr_q   <= 1'b0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      sc_q    <= sc_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      ovr_q   <= ovr_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
    end
  end

  assign avg_out   = avg_q;
  assign bcd_hund  = hund_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q == CONV);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Self-checking bench: two adc_avg_bcd instances (4- and 1-sample windows)
// against an arithmetic event model, directed plan cases then random.
module tb_adc_avg_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] si [2];
  logic       sv [2];
  logic [7:0] avg [2];
  logic [3:0] dh [2];
  logic [3:0] dt [2];
  logic [3:0] dn [2];
  logic       bv [2];
  logic       bz [2];
  logic       ov [2];

  adc_avg_bcd #(.AVG_LOG2(2)) u_avg4 (
    .clk(clk), .rst(rst),
    .sample_in(si[0]), .sample_valid(sv[0]),
    .avg_out(avg[0]), .bcd_hund(dh[0]),
    .bcd_tens(dt[0]), .bcd_ones(dn[0]),
    .bcd_valid(bv[0]), .busy(bz[0]),
    .overrun(ov[0])
  );

  adc_avg_bcd #(.AVG_LOG2(0)) u_avg1 (
    .clk(clk), .rst(rst),
    .sample_in(si[1]), .sample_valid(sv[1]),
    .avg_out(avg[1]), .bcd_hund(dh[1]),
    .bcd_tens(dt[1]), .bcd_ones(dn[1]),
    .bcd_valid(bv[1]), .busy(bz[1]),
    .overrun(ov[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit checking = 0;

  int win [2] = '{4, 1};
  int bsum [2];
  int bcnt [2];
  bit act [2];
  int vcyc [2];
  int cval [2];
  bit pnd [2];
  int pval [2];
  bit m_ov [2];
  int m_avg [2];
  int m_h [2];
  int m_t [2];
  int m_o [2];
  bit m_v [2];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    bsum[k] = 0; bcnt[k] = 0; act[k] = 0;
    vcyc[k] = 0; cval[k] = 0; pnd[k] = 0;
    pval[k] = 0; m_ov[k] = 0; m_avg[k] = 0;
    m_h[k] = 0; m_t[k] = 0; m_o[k] = 0;
    m_v[k] = 0;
  endtask

  // State after the edge that closes cycle c.
  task automatic model_step(input int k, input int c,
                            input bit v, input int d);
    int mean;
    m_v[k] = 0;
    if (act[k] && c == vcyc[k] - 1) begin
      m_v[k] = 1;
      m_h[k] = cval[k] / 100;
      m_t[k] = (cval[k] / 10) % 10;
      m_o[k] = cval[k] % 10;
      if (pnd[k]) begin
        cval[k] = pval[k];
        vcyc[k] = c + 10;
        pnd[k] = 0;
      end else begin
        act[k] = 0;
      end
    end
    if (v) begin
      bsum[k] += d;
      bcnt[k]++;
      if (bcnt[k] == win[k]) begin
        mean = bsum[k] / win[k];
        bsum[k] = 0;
        bcnt[k] = 0;
        m_avg[k] = mean;
        if (!act[k]) begin
          act[k] = 1;
          cval[k] = 2 * mean;
          vcyc[k] = c + 10;
        end else if (pnd[k]) begin
          pval[k] = 2 * mean;
          m_ov[k] = 1;
        end else begin
          pnd[k] = 1;
          pval[k] = 2 * mean;
        end
      end
    end
  endtask

  task automatic check_outs(input int k);
    string p;
    p = (k == 0) ? "w4" : "w1";
    chk({p, "_valid"}, int'(bv[k]), int'(m_v[k]));
    chk({p, "_busy"}, int'(bz[k]), int'(act[k]));
    chk({p, "_ovr"}, int'(ov[k]), int'(m_ov[k]));
    chk({p, "_avg"}, int'(avg[k]), m_avg[k]);
    chk({p, "_hund"}, int'(dh[k]), m_h[k]);
    chk({p, "_tens"}, int'(dt[k]), m_t[k]);
    chk({p, "_ones"}, int'(dn[k]), m_o[k]);
  endtask

  // Check the current cycle's outputs, then drive and model the next.
  task automatic step(input bit r, input bit v0, input int d0,
                      input bit v1, input int d1);
    @(negedge clk);
    if (checking) begin
      check_outs(0);
      check_outs(1);
    end
    rst = r;
    sv[0] = v0; si[0] = 8'(d0);
    sv[1] = v1; si[1] = 8'(d1);
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, cyc, v0, d0);
      model_step(1, cyc, v1, d1);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic blk4(input int a, input int b,
                      input int c, input int d);
    step(1, 1, a, 0, 0);
    step(1, 1, b, 0, 0);
    step(1, 1, c, 0, 0);
    step(1, 1, d, 0, 0);
  endtask

  initial begin
    rst = 0;
    sv[0] = 0; sv[1] = 0;
    si[0] = 0; si[1] = 0;
    model_reset(0);
    model_reset(1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checking = 1;
    idle(2);

    blk4(100, 102, 104, 106);
    idle(9);
    chk("tp1_nv9", int'(bv[0]), 0);
    idle(1);
    chk("tp1_v10", int'(bv[0]), 1);
    chk("tp1_avg", int'(avg[0]), 103);
    chk("tp1_dig", {dh[0], dt[0], dn[0]}, 12'h206);
    idle(3);

    blk4(255, 255, 255, 255);
    idle(12);
    chk("fs_dig", {dh[0], dt[0], dn[0]}, 12'h510);
    blk4(0, 0, 0, 0);
    idle(12);
    blk4(0, 0, 0, 3);
    idle(12);
    chk("tr0_avg", int'(avg[0]), 0);
    blk4(1, 1, 1, 2);
    idle(12);
    chk("tr1_dig", {dh[0], dt[0], dn[0]}, 12'h002);

    step(1, 0, 0, 1, 128);
    step(1, 0, 0, 1, 50);
    step(1, 0, 0, 1, 7);
    idle(25);
    chk("w1_ovr", int'(ov[1]), 1);
    chk("w1_dig", {dh[1], dt[1], dn[1]}, 12'h014);

    step(0, 0, 0, 0, 0);
    blk4(50, 50, 50, 50);
    idle(4);
    step(0, 0, 0, 0, 0);
    idle(12);
    chk("rc_busy", int'(bz[0]), 0);
    blk4(30, 30, 30, 30);
    idle(12);

    step(1, 1, 90, 0, 0);
    step(1, 1, 90, 0, 0);
    step(0, 0, 0, 0, 0);
    blk4(20, 20, 20, 20);
    idle(12);
    chk("rb_dig", {dh[0], dt[0], dn[0]}, 12'h040);

    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit a;
      bit b;
      r = ($urandom_range(599) != 0);
      a = ($urandom_range(2) == 0);
      b = ($urandom_range(9) == 0);
      step(r, a, int'($urandom_range(255)),
           b, int'($urandom_range(255)));
    end
    idle(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
